slc3_mem_responder: RTL and testbench
=====================================

Name: slc3_mem_responder

Overview:
- Memory-side responder for the SLC-3 datapath.
- Services the active-high Mem_OE / Mem_WE strobes issued by the control unit, addressed by MAR, with write data from MDR.
- Read data returns with a fixed, parameterised latency so the controller's fixed wait states line up.
- Contains on-chip word RAM plus one memory-mapped I/O word at 0xFFFF: switches on read, hex display register on write.

Parameters:
- ADDR_W, 10, RAM address width; RAM depth is 2^ADDR_W 16-bit words at 0x0000..(2^ADDR_W-1).
- READ_LAT, 1, cycles from the first OE-high cycle to Data_valid; legal range 1..4.
- IO_ADDR, 16'hFFFF, memory-mapped I/O address.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Mem_OE  in  1  read strobe from control unit, held high for the whole read.
- Mem_WE  in  1  write strobe from control unit, held high for the whole write.
- ADDR  in  16  address (MAR).
- Data_from_CPU  in  16  write data (MDR).
- Switches  in  16  board switches, asynchronous to Clk.
- Data_to_CPU  out  16  read data to the MDR input mux.
- Data_valid  out  1  Data_to_CPU is valid for the current read.
- Busy  out  1  high in any state other than IDLE.
- HEX_reg  out  16  hex display register.
- Err  out  1  one-cycle pulse on a protocol or address error.

Behaviour:
- Reset (asynchronous): state IDLE; Data_to_CPU, Data_valid, Busy, HEX_reg, Err and the latency counter all 0; both switch synchroniser stages 0.
- RAM contents are not reset.
- Switches pass through a 2-flop synchroniser; reads of IO_ADDR return the synchronised value.
- Address decode:
  - RAM hit: ADDR[15:ADDR_W] == 0.
  - IO hit: ADDR == IO_ADDR.
  - Anything else is unmapped.
- FSM states: IDLE, RD_WAIT, RD_VALID, WR_HOLD.
- IDLE:
  - OE=1, WE=0: latch ADDR and load counter with READ_LAT-1. Go to RD_VALID if READ_LAT==1, otherwise RD_WAIT.
  - WE=1, OE=0, RAM hit: write Data_from_CPU at this edge; go to WR_HOLD.
  - WE=1, OE=0, IO hit: load HEX_reg at this edge; go to WR_HOLD.
  - WE=1, OE=0, unmapped: no write; pulse Err; go to WR_HOLD.
  - OE=1 and WE=1 together: no action; pulse Err; stay IDLE.
- RD_WAIT: counter decrements each cycle; at 0, go to RD_VALID. OE low in any cycle aborts to IDLE with no Data_valid.
- RD_VALID:
  - Data_valid=1 and Data_to_CPU = data at the latched address (RAM word, synchronised Switches, or 0x0000 if unmapped).
  - An unmapped read pulses Err once, in the first RD_VALID cycle.
  - Data is stable for as long as OE stays high. OE low returns to IDLE; Data_valid drops in that cycle (combinational on state), and Data_to_CPU holds its last value.
- Timing result: OE first high in cycle N gives Data_valid high in cycle N+READ_LAT. With the default READ_LAT=1, data is valid in the controller's second OE cycle, where LD_MDR is asserted.
- WR_HOLD: exactly one write per strobe; stay until WE=0, then IDLE. OE during WR_HOLD is ignored.
- A WE asserted during RD_WAIT or RD_VALID is ignored; the read continues.
- ADDR and Data_from_CPU changes after the initiating edge have no effect on the current transaction.
- Reset mid-transaction: immediate return to IDLE. A RAM write committed at an earlier edge persists; no partial write is possible.
- Busy = (state != IDLE).

Test Plan:
- Write then read, READ_LAT=1: WE=1 with ADDR=0x0012, data 0xBEEF for 2 cycles, then OE=1 for 3 cycles at 0x0012 -> Data_valid rises exactly 1 cycle after OE rises, Data_to_CPU=0xBEEF, Err=0.
- IO access: WE at 0xFFFF with 0x1234 -> HEX_reg=0x1234 from the next cycle. Then Switches=0x00A5 for 3+ cycles and OE at 0xFFFF -> Data_to_CPU=0x00A5.
- READ_LAT=3: OE held 5 cycles -> Data_valid low for cycles N..N+2 and high from N+3. Repeat with OE dropped at N+1 -> Data_valid never rises; state returns to IDLE.
- Unmapped and conflicting strobes:
  - WE at 0x8000 -> one-cycle Err pulse, RAM unchanged.
  - OE at 0x8000 -> Data_to_CPU=0x0000, one-cycle Err pulse.
  - OE=WE=1 in IDLE -> Err pulse, Busy stays 0.
- Single write per strobe: WE held 4 cycles while Data_from_CPU changes each cycle -> RAM holds only the first-cycle value.
- Asynchronous reset asserted during RD_WAIT -> Busy, Data_valid and HEX_reg go to 0 immediately, before the next clock edge; a following read of an earlier-written word returns its data intact.

Source files
------------

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: word RAM plus a memory-mapped switch/hex I/O word,
// answering the control unit's OE/WE strobes with a fixed read latency.
module slc3_mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          READ_LAT = 1,
    parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        Data_valid,
    output logic        Busy,
    output logic [15:0] HEX_reg,
    output logic        Err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_WAIT  = 2'd1;
    localparam logic [1:0] S_RD_VALID = 2'd2;
    localparam logic [1:0] S_WR_HOLD  = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic [15:0] r_dout;
    logic [15:0] r_hex;
    logic        r_err;
    logic [15:0] r_mem [0:(1<<ADDR_W)-1];

    logic [15:0] w_addr;
    logic        w_ram_hit;
    logic        w_io_hit;
    logic [15:0] w_rd_data;
    logic        w_wr_ram;
    logic        w_load_valid;

    // In IDLE the live bus is decoded; once a read is underway only the latched address matters.
    assign w_addr    = (r_state == S_IDLE) ? ADDR : r_addr;
    assign w_io_hit  = (w_addr == IO_ADDR);
    assign w_ram_hit = (w_addr[15:ADDR_W] == '0) && !w_io_hit;

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_io_hit)
            w_rd_data = r_sw_sync;
        else if (w_ram_hit)
            w_rd_data = r_mem[w_addr[ADDR_W-1:0]];
    end

    assign w_wr_ram = (r_state == S_IDLE) && Mem_WE && !Mem_OE && w_ram_hit;

    // Data is captured on the edge that enters RD_VALID, so it is ready in the first valid cycle.
    assign w_load_valid = ((r_state == S_IDLE) && Mem_OE && !Mem_WE && (READ_LAT == 1)) ||
                          ((r_state == S_RD_WAIT) && Mem_OE && (r_cnt == 3'd1));

    always_ff @(posedge Clk) begin
        if (w_wr_ram)
            r_mem[w_addr[ADDR_W-1:0]] <= Data_from_CPU;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sw_meta <= 16'h0000;
            r_sw_sync <= 16'h0000;
        end else begin
            r_sw_meta <= Switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= 16'h0000;
            r_dout  <= 16'h0000;
            r_hex   <= 16'h0000;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_load_valid) begin
                r_dout <= w_rd_data;
                r_err  <= !w_ram_hit && !w_io_hit;
            end
            case (r_state)
                S_IDLE: begin
                    if (Mem_OE && Mem_WE) begin
                        r_err <= 1'b1;
                    end else if (Mem_OE) begin
                        r_addr  <= ADDR;
                        r_cnt   <= 3'(READ_LAT - 1);
                        r_state <= (READ_LAT == 1) ? S_RD_VALID : S_RD_WAIT;
                    end else if (Mem_WE) begin
                        if (w_io_hit)
                            r_hex <= Data_from_CPU;
                        else if (!w_ram_hit)
                            r_err <= 1'b1;
                        r_state <= S_WR_HOLD;
                    end
                end
                S_RD_WAIT: begin
                    if (!Mem_OE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1)
                            r_state <= S_RD_VALID;
                    end
                end
                S_RD_VALID: begin
                    if (!Mem_OE)
                        r_state <= S_IDLE;
                end
                default: begin
                    if (!Mem_WE)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Data_to_CPU = r_dout;
    assign Data_valid  = (r_state == S_RD_VALID);
    assign Busy        = (r_state != S_IDLE);
    assign HEX_reg     = r_hex;
    assign Err         = r_err;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: a READ_LAT=1 and a READ_LAT=3 instance share one bus
// and are checked against a word-array model of the memory map.
module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        OE, WE;
    logic [15:0] ADDR, DIN, SW;

    logic [15:0] dout1, dout3, hex1, hex3;
    logic        dv1, dv3, busy1, busy3, err1, err3;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem_m [0:1023];
    logic [15:0] hex_m;
    logic [15:0] sw_m;
    logic [15:0] wq [$];

    always #5 Clk = ~Clk;

    slc3_mem_responder #(.ADDR_W(10), .READ_LAT(1), .IO_ADDR(16'hFFFF)) u1 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(OE), .Mem_WE(WE), .ADDR(ADDR),
        .Data_from_CPU(DIN), .Switches(SW), .Data_to_CPU(dout1), .Data_valid(dv1),
        .Busy(busy1), .HEX_reg(hex1), .Err(err1));

    slc3_mem_responder #(.ADDR_W(10), .READ_LAT(3), .IO_ADDR(16'hFFFF)) u3 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(OE), .Mem_WE(WE), .ADDR(ADDR),
        .Data_from_CPU(DIN), .Switches(SW), .Data_to_CPU(dout3), .Data_valid(dv3),
        .Busy(busy3), .HEX_reg(hex3), .Err(err3));

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        if (a == 16'hFFFF) return sw_m;
        if (a < 16'd1024)  return mem_m[a[9:0]];
        return 16'h0000;
    endfunction

    function automatic bit unm(input logic [15:0] a);
        return !(a == 16'hFFFF || a < 16'd1024);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int hold);
        bit um = unm(a);
        for (int i = 0; i < hold; i++) begin
            tick();
            OE = 1'b0; WE = 1'b1;
            ADDR = (i == 0) ? a : 16'($urandom);
            DIN  = (i == 0) ? d : 16'($urandom);
            #1;
            if (i > 0) begin
                checks++; if (err1 !== (i == 1 && um)) begin errors++; $display("FAIL wr_err1 a=%h i=%0d: got %b want %b", a, i, err1, (i == 1 && um)); end
                checks++; if (err3 !== (i == 1 && um)) begin errors++; $display("FAIL wr_err3 a=%h i=%0d: got %b want %b", a, i, err3, (i == 1 && um)); end
                checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL wr_busy a=%h i=%0d: got %b want 1", a, i, busy1); end
                checks++; if (hex1 !== hex_m) begin errors++; $display("FAIL wr_hex a=%h i=%0d: got %h want %h", a, i, hex1, hex_m); end
            end else begin
                if (a == 16'hFFFF) hex_m = d;
                else if (a < 16'd1024) begin mem_m[a[9:0]] = d; wq.push_back(a); end
            end
        end
        tick();
        WE = 1'b0; ADDR = 16'($urandom);
        #1;
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL wr_err_end a=%h: got %b want 0", a, err1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL wr_busy_end a=%h: got %b want 1", a, busy1); end
        tick();
        #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL wr_idle a=%h: got %b want 0", a, busy1); end
    endtask

    task automatic do_read(input logic [15:0] a, input int hold);
        logic [15:0] exp = exp_rd(a);
        bit um = unm(a);
        for (int i = 0; i < hold; i++) begin
            tick();
            OE = 1'b1;
            WE   = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            ADDR = (i == 0) ? a : 16'($urandom);
            DIN  = 16'($urandom);
            #1;
            checks++; if (dv1 !== (i >= 1)) begin errors++; $display("FAIL rd_dv1 a=%h i=%0d: got %b want %b", a, i, dv1, (i >= 1)); end
            checks++; if (dv3 !== (i >= 3)) begin errors++; $display("FAIL rd_dv3 a=%h i=%0d: got %b want %b", a, i, dv3, (i >= 3)); end
            checks++; if (err1 !== (i == 1 && um)) begin errors++; $display("FAIL rd_err1 a=%h i=%0d: got %b want %b", a, i, err1, (i == 1 && um)); end
            checks++; if (err3 !== (i == 3 && um)) begin errors++; $display("FAIL rd_err3 a=%h i=%0d: got %b want %b", a, i, err3, (i == 3 && um)); end
            if (i >= 1) begin
                checks++; if (dout1 !== exp) begin errors++; $display("FAIL rd_data1 a=%h i=%0d: got %h want %h", a, i, dout1, exp); end
            end
            if (i >= 3) begin
                checks++; if (dout3 !== exp) begin errors++; $display("FAIL rd_data3 a=%h i=%0d: got %h want %h", a, i, dout3, exp); end
            end
        end
        tick();
        OE = 1'b0; WE = 1'b0;
        #1;
        checks++; if (err1 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL rd_err_end a=%h: got %b/%b want 0/0", a, err1, err3); end
        tick();
        #1;
        checks++; if (dv1 !== 1'b0 || dv3 !== 1'b0) begin errors++; $display("FAIL rd_dv_drop a=%h: got %b/%b want 0/0", a, dv1, dv3); end
        checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL rd_idle a=%h: got %b/%b want 0/0", a, busy1, busy3); end
        checks++; if (dout1 !== exp || dout3 !== exp) begin errors++; $display("FAIL rd_hold a=%h: got %h/%h want %h", a, dout1, dout3, exp); end
    endtask

    task automatic set_switches(input logic [15:0] v);
        SW = v; sw_m = v;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; OE = 1'b0; WE = 1'b0; ADDR = 16'h0; DIN = 16'h0; SW = 16'h0; sw_m = 16'h0;
        hex_m = 16'h0;
        repeat (2) tick();
        #1;
        checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b/%b want 0/0", busy1, busy3); end
        checks++; if (dv1 !== 1'b0 || dv3 !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b/%b want 0/0", dv1, dv3); end
        checks++; if (dout1 !== 16'h0 || dout3 !== 16'h0) begin errors++; $display("FAIL rst_dout: got %h/%h want 0000", dout1, dout3); end
        checks++; if (hex1 !== 16'h0 || hex3 !== 16'h0) begin errors++; $display("FAIL rst_hex: got %h/%h want 0000", hex1, hex3); end
        checks++; if (err1 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b/%b want 0/0", err1, err3); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        do_write(16'h0012, 16'hBEEF, 2);
        do_read(16'h0012, 5);
    endtask

    task automatic test_io();
        do_write(16'hFFFF, 16'h1234, 2);
        checks++; if (hex1 !== 16'h1234) begin errors++; $display("FAIL io_hex: got %h want 1234", hex1); end
        set_switches(16'h00A5);
        do_read(16'hFFFF, 5);
    endtask

    task automatic test_abort();
        do_write(16'h0077, 16'h7777, 2);
        tick(); OE = 1'b1; ADDR = 16'h0077; #1;
        checks++; if (dv3 !== 1'b0) begin errors++; $display("FAIL abort_dv_n: got %b want 0", dv3); end
        tick(); OE = 1'b0; #1;
        checks++; if (dv3 !== 1'b0 || busy3 !== 1'b1) begin errors++; $display("FAIL abort_n1: got dv=%b busy=%b want 0/1", dv3, busy3); end
        checks++; if (dv1 !== 1'b1 || dout1 !== 16'h7777) begin errors++; $display("FAIL abort_lat1: got dv=%b d=%h want 1/7777", dv1, dout1); end
        repeat (3) begin
            tick(); #1;
            checks++; if (dv3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL abort_after: got dv=%b busy=%b want 0/0", dv3, busy3); end
        end
    endtask

    task automatic test_unmapped();
        do_write(16'h0000, 16'h5A5A, 2);
        do_write(16'h8000, 16'hDEAD, 3);
        do_read(16'h0000, 4);
        do_read(16'h8000, 4);
    endtask

    task automatic test_conflict();
        tick(); OE = 1'b1; WE = 1'b1; ADDR = 16'h0012; DIN = 16'h1111; #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL conf_busy0: got %b want 0", busy1); end
        tick(); OE = 1'b0; WE = 1'b0; #1;
        checks++; if (err1 !== 1'b1 || err3 !== 1'b1) begin errors++; $display("FAIL conf_err: got %b/%b want 1/1", err1, err3); end
        checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL conf_busy1: got %b/%b want 0/0", busy1, busy3); end
        tick(); #1;
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL conf_err_pulse: got %b want 0", err1); end
        do_read(16'h0012, 4);
    endtask

    task automatic test_single_write();
        do_write(16'h0100, 16'hC0DE, 4);
        do_read(16'h0100, 4);
    endtask

    task automatic test_reset_mid();
        do_write(16'hFFFF, 16'hABCD, 2);
        do_write(16'h0055, 16'h2468, 2);
        tick(); OE = 1'b1; ADDR = 16'h0055; #1;
        tick(); #1;
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b want 1", busy3); end
        Reset = 1'b1;
        #1;
        checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b/%b want 0/0", busy1, busy3); end
        checks++; if (dv1 !== 1'b0 || dv3 !== 1'b0) begin errors++; $display("FAIL mid_dv: got %b/%b want 0/0", dv1, dv3); end
        checks++; if (hex1 !== 16'h0 || hex3 !== 16'h0) begin errors++; $display("FAIL mid_hex: got %h/%h want 0000", hex1, hex3); end
        Reset = 1'b0; OE = 1'b0;
        hex_m = 16'h0;
        repeat (3) tick();
        do_read(16'h0055, 5);
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) set_switches(16'($urandom));
            case ($urandom_range(0, 5))
                0: begin a = 16'($urandom_range(0, 1023)); do_write(a, 16'($urandom), $urandom_range(2, 4)); end
                1: do_write(16'hFFFF, 16'($urandom), 2);
                2: do_write(16'($urandom_range(16'h0400, 16'hFFFE)), 16'($urandom), 2);
                3: if (wq.size() > 0) do_read(wq[$urandom_range(0, wq.size() - 1)], $urandom_range(4, 6));
                4: do_read(16'hFFFF, 4);
                default: do_read(16'($urandom_range(16'h0400, 16'hFFFE)), 4);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_io();
        test_abort();
        test_unmapped();
        test_conflict();
        test_single_write();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
